// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Optional feature macro used by the top: REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NRD   = 2;

  // Low bit of slice idx within a packed bus of width-bit fields
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_rdport.sv
// One combinational read port: selects a register and its busy bit,
// forces register 0 to zero when it is hard-wired, and optionally
// forwards the data being written this cycle.
module reg_file_sb_rdport
  import reg_file_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int ZERO_R0 = 1,
  parameter bit BYPASS  = 1'b0
) (
  input  logic [DW-1:0]    regs [DEPTH],
  input  logic [DEPTH-1:0] busy,
  input  logic [AW-1:0]    addr,
  input  logic             byp_en,
  input  logic [AW-1:0]    byp_addr,
  input  logic [DW-1:0]    byp_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DW-1:0]    data,
  output logic             data_busy
);

  logic is_zero_reg;
  logic byp_hit;
  logic rsv_hit;

  assign is_zero_reg = (ZERO_R0 != 0) && (addr == '0);
  assign byp_hit     = BYPASS && byp_en && (byp_addr == addr);
  assign rsv_hit     = rsv_en && (rsv_addr == addr);

  // Read mux: hard zero first, then forwarded write data, then storage.
  // A pending reserve of the same register keeps the stored busy bit visible.
  always_comb begin
    data      = regs[addr];
    data_busy = busy[addr];
    if (is_zero_reg) begin
      data      = '0;
      data_busy = 1'b0;
    end else if (byp_hit) begin
      data = byp_data;
      if (!rsv_hit) begin
        data_busy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int NRD     = DEF_NRD,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [AW-1:0]     write_reg,
  input  logic [DW-1:0]     write_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_reg,
  input  logic [NRD*AW-1:0] read_reg,
  output logic [NRD*DW-1:0] read_data,
  output logic [NRD-1:0]    read_busy,
  output logic              any_busy
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_ok;
  logic             rsv_ok;
  logic             byp_en;

  // Register 0 silently drops writes and reserves when hard-wired to zero
  assign wr_ok  = RegWrite && !((ZERO_R0 != 0) && (write_reg == '0));
  assign rsv_ok = rsv_en && !((ZERO_R0 != 0) && (rsv_reg == '0));
  assign byp_en = wr_ok && rst_n;

  // Data storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[write_reg] <= write_data;
    end
  end

  // Busy scoreboard: a write clears, a reserve sets; the reserve is applied
  // last so it wins when both target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_ok) begin
        busy[write_reg] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_reg] <= 1'b1;
      end
    end
  end

  assign any_busy = |busy;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    reg_file_sb_rdport #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .regs      (regs),
      .busy      (busy),
      .addr      (read_reg[slice_lo(g, AW) +: AW]),
      .byp_en    (byp_en),
      .byp_addr  (write_reg),
      .byp_data  (write_data),
      .rsv_en    (rsv_ok),
      .rsv_addr  (rsv_reg),
      .data      (read_data[slice_lo(g, DW) +: DW]),
      .data_busy (read_busy[g])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb (default parameters: 16x8, 2 read ports,
// hard-zero register 0). Expectations for the same-cycle read follow
// REG_FILE_BYPASS_EN.
module tb_reg_file_sb;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int NRD = 2;

  logic              clk;
  logic              rst_n;
  logic              RegWrite;
  logic [AW-1:0]     write_reg;
  logic [DW-1:0]     write_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_reg;
  logic [NRD*AW-1:0] read_reg;
  logic [NRD*DW-1:0] read_data;
  logic [NRD-1:0]    read_busy;
  logic              any_busy;

  typedef struct {
    string             name;
    logic [NRD*DW-1:0] data;
    logic [NRD-1:0]    busy;
    logic              any;
  } exp_t;

  exp_t expq[$];
  event check_ev;
  int   n_compared;
  int   n_mismatched;

  reg_file_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .rsv_en     (rsv_en),
    .rsv_reg    (rsv_reg),
    .read_reg   (read_reg),
    .read_data  (read_data),
    .read_busy  (read_busy),
    .any_busy   (any_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: pops one expectation per presentation and compares outputs
  initial begin
    exp_t e;
    n_compared   = 0;
    n_mismatched = 0;
    forever begin
      @(check_ev);
      while (expq.size() > 0) begin
        e = expq.pop_front();
        n_compared++;
        if (read_data !== e.data) begin
          n_mismatched++;
          $display("[TB] FAIL %s read_data: actual=%h required=%h", e.name, read_data, e.data);
        end
        n_compared++;
        if (read_busy !== e.busy) begin
          n_mismatched++;
          $display("[TB] FAIL %s read_busy: actual=%b required=%b", e.name, read_busy, e.busy);
        end
        n_compared++;
        if (any_busy !== e.any) begin
          n_mismatched++;
          $display("[TB] FAIL %s any_busy: actual=%b required=%b", e.name, any_busy, e.any);
        end
      end
    end
  end

  // Drive write/reserve controls just after a falling edge
  task automatic applyStimulus(input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic re, input int ra);
    @(negedge clk);
    RegWrite   = we;
    write_reg  = AW'(wa);
    write_data = wd;
    rsv_en     = re;
    rsv_reg    = AW'(ra);
  endtask

  // Let the next rising edge take the controls, then idle them
  task automatic step();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    rsv_en   = 1'b0;
  endtask

  // Address both ports, then hand the expected response to the monitor
  task automatic checkOutput(input string name, input int r0, input int r1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [1:0] b, input logic a);
    exp_t e;
    read_reg = {AW'(r1), AW'(r0)};
    #1;
    e.name = name;
    e.data = {d1, d0};
    e.busy = b;
    e.any  = a;
    expq.push_back(e);
    ->check_ev;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    RegWrite   = 1'b0;
    write_reg  = '0;
    write_data = '0;
    rsv_en     = 1'b0;
    rsv_reg    = '0;
    read_reg   = '0;

    #2;
    checkOutput("reset_initial", 3, 5, 16'h0000, 16'h0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read on both ports
    applyStimulus(1'b1, 5, 16'hBEEF, 1'b0, 0);
    step();
    checkOutput("write_read_r5", 5, 5, 16'hBEEF, 16'hBEEF, 2'b00, 1'b0);

    // Hard-zero register 0 ignores write and reserve
    applyStimulus(1'b1, 0, 16'h1234, 1'b1, 0);
    step();
    checkOutput("r0_zero", 0, 5, 16'h0000, 16'hBEEF, 2'b00, 1'b0);

    // Reserve r3, two idle cycles, then the write clears it
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 3);
    step();
    checkOutput("rsv3_c0", 3, 5, 16'h0000, 16'hBEEF, 2'b01, 1'b1);
    step();
    checkOutput("rsv3_c1", 3, 5, 16'h0000, 16'hBEEF, 2'b01, 1'b1);
    step();
    checkOutput("rsv3_c2", 5, 3, 16'hBEEF, 16'h0000, 2'b10, 1'b1);
    applyStimulus(1'b1, 3, 16'h0042, 1'b0, 0);
    step();
    checkOutput("rsv3_written", 3, 5, 16'h0042, 16'hBEEF, 2'b00, 1'b0);

    // Same-register write and reserve: data lands, busy ends set
    applyStimulus(1'b1, 6, 16'h00AA, 1'b1, 6);
    step();
    checkOutput("wr_rsv_same6", 6, 3, 16'h00AA, 16'h0042, 2'b01, 1'b1);

    // Different registers: write clears r6, reserve sets r2
    applyStimulus(1'b1, 6, 16'h00BB, 1'b1, 2);
    step();
    checkOutput("wr6_rsv2", 6, 2, 16'h00BB, 16'h0000, 2'b10, 1'b1);

    // Same-cycle read of a register being written
    applyStimulus(1'b1, 4, 16'h1111, 1'b0, 0);
    step();
    applyStimulus(1'b1, 4, 16'h5A5A, 1'b0, 0);
`ifdef REG_FILE_BYPASS_EN
    checkOutput("same_cycle_r4", 4, 2, 16'h5A5A, 16'h0000, 2'b10, 1'b1);
`else
    checkOutput("same_cycle_r4", 4, 2, 16'h1111, 16'h0000, 2'b10, 1'b1);
`endif
    step();
    checkOutput("after_edge_r4", 4, 2, 16'h5A5A, 16'h0000, 2'b10, 1'b1);

    // Same-cycle read of register 0 while it is being written stays zero
    applyStimulus(1'b1, 0, 16'hFFFF, 1'b0, 0);
    checkOutput("same_cycle_r0", 0, 4, 16'h0000, 16'h5A5A, 2'b00, 1'b1);
    step();

    // Reserve idempotence on r2, then clear it with a write
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 2);
    step();
    checkOutput("rsv2_again", 2, 6, 16'h0000, 16'h00BB, 2'b01, 1'b1);
    applyStimulus(1'b1, 2, 16'h0077, 1'b0, 0);
    step();
    checkOutput("wr2_clear", 2, 6, 16'h0077, 16'h00BB, 2'b00, 1'b0);

    // RegWrite low must leave data and busy alone
    applyStimulus(1'b0, 5, 16'hDEAD, 1'b0, 0);
    step();
    checkOutput("no_write", 5, 2, 16'hBEEF, 16'h0077, 2'b00, 1'b0);

    // Asynchronous mid-run reset with a pending reservation
    applyStimulus(1'b0, 0, 16'h0000, 1'b1, 5);
    step();
    checkOutput("pre_reset", 3, 5, 16'h0042, 16'hBEEF, 2'b10, 1'b1);
    rst_n = 1'b0;
    checkOutput("reset_async", 3, 5, 16'h0000, 16'h0000, 2'b00, 1'b0);

    // Activity during reset has no effect
    applyStimulus(1'b1, 3, 16'h9999, 1'b1, 3);
    checkOutput("reset_wr_ignored", 3, 5, 16'h0000, 16'h0000, 2'b00, 1'b0);
    step();
    checkOutput("reset_held", 3, 5, 16'h0000, 16'h0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_released", 3, 5, 16'h0000, 16'h0000, 2'b00, 1'b0);

    #2;
    n_compared++;
    if (expq.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x16 multi-cycle register file: configurable width, depth and read-port count.
- Adds an asynchronous clear and an optional hard-zero register 0.
- Adds a per-register busy scoreboard so the multi-cycle controller can stall on pending writes.
- Sits between the controller/datapath and the ALU operand muxes.

Parameters:
- DW, 16, data width in bits.
- DEPTH, 8, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), register address width.
- NRD, 2, number of combinational read ports, 1..4.
- ZERO_R0, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RegWrite  input  1  write enable.
- write_reg  input  AW  write address.
- write_data  input  DW  write data.
- rsv_en  input  1  reserve request: marks a register as having a pending write.
- rsv_reg  input  AW  register to reserve.
- read_reg  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- read_data  output  NRD*DW  packed read data; port i uses bits [i*DW +: DW].
- read_busy  output  NRD  busy flag of each addressed register.
- any_busy  output  1  OR of all busy bits.

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear to 0 and all busy bits clear to 0. read_data is 0 and read_busy is 0 for any address; any_busy is 0. Reset is held until rst_n rises; no write or reserve takes effect while rst_n is low.
- Write: on posedge clk with RegWrite=1, regs[write_reg] <= write_data and busy[write_reg] <= 0.
- Read: fully combinational, zero latency. read_data[i] = regs[read_reg[i]] and read_busy[i] = busy[read_reg[i]], both from current state.
- Reserve: on posedge clk with rsv_en=1, busy[rsv_reg] <= 1.
- Same register written and reserved in the same cycle: data is written and busy ends at 1. The new reservation wins.
- Different registers written and reserved in the same cycle: both take effect independently.
- ZERO_R0=1: writes to address 0 are dropped, reserves of address 0 are dropped, and reads of address 0 return 0 with busy 0.
- ZERO_R0=0: register 0 behaves like any other register.
- Several read ports may address the same register; all see identical values.
- Write with RegWrite=0: no state change, including busy.
- A write to a register that is not busy is legal and leaves busy at 0.
- Reserving a register that is already busy is legal and idempotent.
- Addresses are always in range because DEPTH is a power of two.
- any_busy is combinational from the busy vector.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through bypass. When RegWrite=1, write_reg==read_reg[i] and the address is writable (not register 0 under ZERO_R0), read_data[i]=write_data and read_busy[i]=0 in that same cycle.
- Defined, same-cycle reserve: read_busy[i] still reflects the pre-edge busy bit; bypass affects data and the write-side busy clear only.
- Not defined: reads return the stored value; new data is visible the cycle after the write edge.

Decomposition:
- Shared package reg_file_pkg: default DW/DEPTH/NRD constants, and the function for the packed-slice index.
- One natural sub-module, reg_file_sb_rdport: a single read mux with zero-forcing and bypass, instantiated NRD times by a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset check: with rst_n=0 mid-simulation after writes, set read_reg={3,5}. Required: read_data=0, read_busy=0, any_busy=0, immediately and asynchronously without a clock edge.
- Write then read: write 16'hBEEF to register 5. Required: on the next cycle port 0 with read_reg=5 returns 16'hBEEF, and other ports addressing 5 match.
- Register 0 (ZERO_R0=1): write 16'h1234 to register 0 and reserve register 0. Required: reads of register 0 return 0, busy 0, any_busy 0.
- Scoreboard: reserve register 3, then two idle cycles, then write 16'h0042 to register 3. Required: read_busy=1 and any_busy=1 for those cycles; both go to 0 after the write edge and data reads 16'h0042.
- Simultaneous write and reserve of register 6 with data 16'h00AA. Required: data reads 16'h00AA and busy[6]=1. In a second cycle, write register 6 and reserve register 2. Required: busy[6]=0, busy[2]=1.
- Bypass (REG_FILE_BYPASS_EN defined): RegWrite=1, write_reg=4, write_data=16'h5A5A, read_reg[0]=4. Required: read_data[0]=16'h5A5A in the same cycle. Without the macro, the same-cycle read returns the old value of register 4.
